// File: rtl/rv32i_types_pkg.sv
// Shared RV32 pipeline types: data word, write-back source selects, FP flag width.
// Imported by the write-back stage and its flag accumulator.
// Ports: none (package only).
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam int FFLAGS_W = 5;

  // Integer write-back data source; codes 5-7 select zero.
  typedef enum logic [2:0] {
    WB_DLOAD = 3'd0,
    WB_PC4   = 3'd1,
    WB_IMMU  = 3'd2,
    WB_ALU   = 3'd3,
    WB_CSR   = 3'd4
  } wb_wsel_t;

  // FP write-back data source; codes 3-7 select zero.
  typedef enum logic [2:0] {
    FWB_LOAD = 3'd0,
    FWB_FPU  = 3'd1,
    FWB_MOVE = 3'd2
  } fwb_wsel_t;

endpackage

// File: rtl/wb_fflags_accum.sv
// Sticky accrued FP exception flags (NV,DZ,OF,UF,NX) with CSR overwrite.
// Ports: clk/rst (sync active-high), wr_en/wr_data CSR write, acc_en/acc_flags
// new flags to accrue, flags registered sticky value.
module wb_fflags_accum
  import rv32i_types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [FFLAGS_W-1:0] wr_data,
  input  logic                acc_en,
  input  logic [FFLAGS_W-1:0] acc_flags,
  output logic [FFLAGS_W-1:0] flags
);

  // CSR write replaces the base value first; flags raised by the instruction
  // retiring on the same edge are still OR-ed on top so none are lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else begin
      flags <= (wr_en ? wr_data : flags) | (acc_en ? acc_flags : '0);
    end
  end

endmodule

// File: rtl/pipe5_writeback_stage.sv
// Write-back stage: selects int/FP write data, drives registered RF write ports,
// accrues FP flags, reports retirement and sequences halt (RUN->DRAIN->HALTED).
// Ports: CLK/RST (sync active-high), flattened mem/wb bundle + mw_valid in;
// rf_*/frf_* write ports, fflags, retire_*, instret, halt out. 1-cycle latency.
// Optional: define WB_INSTRET_EN to build the retired-instruction counter.
module pipe5_writeback_stage
  import rv32i_types_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 mw_valid,
  input  logic [2:0]           w_sel,
  input  logic                 wen,
  input  logic [4:0]           reg_rd,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      pc4,
  input  logic [XLEN-1:0]      dload_ext,
  input  logic [XLEN-1:0]      alu_port_out,
  input  logic [XLEN-1:0]      csr_rdata,
  input  logic [XLEN-1:0]      imm_U,
  input  logic                 halt_instr,
  input  logic                 f_wen,
  input  logic [4:0]           f_reg_rd,
  input  logic [2:0]           f_wsel,
  input  logic [XLEN-1:0]      f_wdata,
  input  logic [XLEN-1:0]      fpu_out,
  input  logic [4:0]           fpu_flags,
  input  logic                 fflags_wen,
  input  logic [4:0]           fflags_wdata,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 frf_wen,
  output logic [4:0]           frf_waddr,
  output logic [XLEN-1:0]      frf_wdata,
  output logic [4:0]           fflags,
  output logic                 retire_valid,
  output logic [XLEN-1:0]      retire_pc,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state, state_nxt;
  logic            accepted;
  logic            int_wr, fp_wr;
  logic [XLEN-1:0] int_data, fp_data;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accepted  = 1'b0;
    case (state)
      RUN: begin
        accepted = mw_valid;
        if (mw_valid && halt_instr) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  assign halt = (state == HALTED);

  // ---------------- data selection ----------------
  always_comb begin
    int_data = '0;
    case (wb_wsel_t'(w_sel))
      WB_DLOAD: int_data = dload_ext;
      WB_PC4:   int_data = pc4;
      WB_IMMU:  int_data = imm_U;
      WB_ALU:   int_data = alu_port_out;
      WB_CSR:   int_data = csr_rdata;
      default:  int_data = '0;
    endcase
  end

  always_comb begin
    fp_data = '0;
    case (fwb_wsel_t'(f_wsel))
      FWB_LOAD: fp_data = f_wdata;
      FWB_FPU:  fp_data = fpu_out;
      FWB_MOVE: fp_data = alu_port_out;
      default:  fp_data = '0;
    endcase
  end

  // x0 is hardwired zero, so its writes are dropped here; f0 is a real register.
  assign int_wr = accepted && wen && (reg_rd != 5'd0);
  assign fp_wr  = accepted && f_wen;

  // ---------------- registered write/retire ports ----------------
  // Address/data/PC registers only load on a strobe and otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      frf_wen      <= 1'b0;
      frf_waddr    <= '0;
      frf_wdata    <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
    end else begin
      rf_wen       <= int_wr;
      frf_wen      <= fp_wr;
      retire_valid <= accepted;
      if (int_wr) begin
        rf_waddr <= reg_rd;
        rf_wdata <= int_data;
      end
      if (fp_wr) begin
        frf_waddr <= f_reg_rd;
        frf_wdata <= fp_data;
      end
      if (accepted) retire_pc <= pc;
    end
  end

  wb_fflags_accum u_fflags (
    .clk       (CLK),
    .rst       (RST),
    .wr_en     (fflags_wen),
    .wr_data   (fflags_wdata),
    .acc_en    (fp_wr),
    .acc_flags (fpu_flags),
    .flags     (fflags)
  );

`ifdef WB_INSTRET_EN
  always_ff @(posedge CLK) begin
    if (RST)               instret <= '0;
    else if (retire_valid) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
  end
`else
  assign instret = '0;
`endif

endmodule
